// File: rtl/hazard_stall_controller.sv
// ============================================================================
// Module      : hazard_stall_controller
// Description : Load-use / ID-branch / MUL-DIV stall control for the 5-stage
//               pipeline, with a saturating stall-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_controller #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDUsesRt,
    input  logic             IDBranch,
    input  logic             IDBranchTaken,
    input  logic             IDMulDivStart,
    input  logic             IDReadsHiLo,
    input  logic             EXRegWrite,
    input  logic             EXMemRead,
    input  logic [4:0]       EXrd,
    input  logic             MemMemRead,
    input  logic [4:0]       Memrd,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXBubble,
    output logic             IFIDFlush,
    output logic             MulDivGo,
    output logic             MulDivBusy,
    output logic             MulDivDone,
    output logic [CNT_W-1:0] StallCycles
);

    localparam int MD_W = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    md_state_t        state_q;
    logic [MD_W-1:0]  md_cnt_q;
    logic             done_q;
    logic [CNT_W-1:0] stall_cnt_q;

    logic w_load_use;
    logic w_br_ex;
    logic w_br_mem;
    logic w_md_haz;
    logic w_stall;
    logic w_run;

    // $zero is hard-wired, so it can never be a real producer.
    function automatic logic id_match(input logic [4:0] r, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic uses_rt);
        return (r != 5'd0) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    assign w_load_use = EXMemRead & id_match(EXrd, IDrs, IDrt, IDUsesRt);
    assign w_br_ex    = IDBranch & EXRegWrite & id_match(EXrd, IDrs, IDrt, IDUsesRt);
    assign w_br_mem   = IDBranch & MemMemRead & id_match(Memrd, IDrs, IDrt, IDUsesRt);
    assign w_md_haz   = MulDivBusy & (IDReadsHiLo | IDMulDivStart);
    assign w_stall    = w_load_use | w_br_ex | w_br_mem | w_md_haz;

    // While reset is asserted the pipeline is held in the safe stall pattern.
    assign w_run      = Rst & ~w_stall;

    assign PCWrite     = w_run;
    assign IFIDWrite   = w_run;
    assign IDEXBubble  = ~w_run;
    assign IFIDFlush   = w_run & IDBranch & IDBranchTaken;
    assign MulDivGo    = w_run & IDMulDivStart;
    assign MulDivBusy  = (state_q == MD_BUSY);
    assign MulDivDone  = done_q;
    assign StallCycles = stall_cnt_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= MD_IDLE;
            md_cnt_q    <= '0;
            done_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            case (state_q)
                MD_IDLE: begin
                    if (MulDivGo) begin
                        state_q  <= MD_BUSY;
                        md_cnt_q <= MD_W'(MULDIV_LAT - 1);
                    end
                end
                MD_BUSY: begin
                    if (md_cnt_q == '0) begin
                        state_q <= MD_IDLE;
                        done_q  <= 1'b1;
                    end else begin
                        md_cnt_q <= md_cnt_q - MD_W'(1);
                    end
                end
                default: state_q <= MD_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
